// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for one data-memory requester port.
// master = requester side, slave = arbiter side.
interface dmem_port_if;
    logic        req;
    logic        we;
    logic        lock;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, we, lock, addr, wdata,
                    input  gnt, rvalid, rdata, err);
    modport slave  (input  req, we, lock, addr, wdata,
                    output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (A = core LSU, B = loader/debug) arbiter in front of a
// single-ported data memory with combinational read and posedge write.
// Supports locked (atomic RMW) ownership with an idle timeout.
// Optional feature: define DMEM_ARB_RR_EN for round-robin tie-break in ARB;
// when undefined, port A wins every tie (fixed priority).
module dmem_arbiter #(
    parameter int LOCK_TIMEOUT = 16,
    parameter int MEM_WORDS    = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_port_if.slave  a,
    dmem_port_if.slave  b,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        lock_timeout
);
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {ARB, LOCK_A, LOCK_B} state_t;

    state_t        state;
    logic [CW-1:0] idle_cnt;
`ifdef DMEM_ARB_RR_EN
    logic          ptr_b;   // 1: B wins the next tie
`endif

    logic        sel_a, sel_b, gnt_a, gnt_b, any_gnt;
    logic        g_we, g_err;
    logic [31:0] g_addr, g_wdata;

    logic        a_rv_q, a_err_q, b_rv_q, b_err_q;
    logic [31:0] a_rd_q, b_rd_q;

    function automatic logic addr_err(input logic [31:0] ad);
        return (ad[1:0] != 2'b00) || ({2'b00, ad[31:2]} >= 32'(MEM_WORDS));
    endfunction

    // Pick the port allowed to access memory this cycle
    always_comb begin
        sel_a = 1'b0;
        sel_b = 1'b0;
        case (state)
            ARB: begin
                if (a.req && b.req) begin
`ifdef DMEM_ARB_RR_EN
                    if (ptr_b) sel_b = 1'b1;
                    else       sel_a = 1'b1;
`else
                    sel_a = 1'b1;
`endif
                end else begin
                    sel_a = a.req;
                    sel_b = b.req;
                end
            end
            LOCK_A:  sel_a = a.req;
            LOCK_B:  sel_b = b.req;
            default: ;
        endcase
    end

    // Grants are suppressed while reset is held
    assign gnt_a   = sel_a & rst_n;
    assign gnt_b   = sel_b & rst_n;
    assign any_gnt = gnt_a | gnt_b;
    assign a.gnt   = gnt_a;
    assign b.gnt   = gnt_b;

    // Memory-side mux; erroring accesses never write
    always_comb begin
        g_we    = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        if (gnt_a) begin
            g_we    = a.we;
            g_addr  = a.addr;
            g_wdata = a.wdata;
        end else if (gnt_b) begin
            g_we    = b.we;
            g_addr  = b.addr;
            g_wdata = b.wdata;
        end
    end

    assign g_err     = any_gnt & addr_err(g_addr);
    assign mem_we    = any_gnt & g_we & ~g_err;
    assign mem_addr  = g_addr;
    assign mem_wdata = g_wdata;

    // Lock FSM, idle timeout counter and tie-break pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ARB;
            idle_cnt     <= '0;
            lock_timeout <= 1'b0;
        end else begin
            lock_timeout <= 1'b0;
            case (state)
                ARB: begin
                    idle_cnt <= '0;
                    if (gnt_a && a.lock)      state <= LOCK_A;
                    else if (gnt_b && b.lock) state <= LOCK_B;
                end
                LOCK_A: begin
                    if (gnt_a) begin
                        idle_cnt <= '0;
                        if (!a.lock) state <= ARB;
                    end else if (idle_cnt == CW'(LOCK_TIMEOUT - 1)) begin
                        state        <= ARB;
                        idle_cnt     <= '0;
                        lock_timeout <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                LOCK_B: begin
                    if (gnt_b) begin
                        idle_cnt <= '0;
                        if (!b.lock) state <= ARB;
                    end else if (idle_cnt == CW'(LOCK_TIMEOUT - 1)) begin
                        state        <= ARB;
                        idle_cnt     <= '0;
                        lock_timeout <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

`ifdef DMEM_ARB_RR_EN
    // After an ARB-state grant the other port gets the next tie
    always_ff @(posedge clk) begin
        if (!rst_n)                      ptr_b <= 1'b0;
        else if (state == ARB && gnt_a)  ptr_b <= 1'b1;
        else if (state == ARB && gnt_b)  ptr_b <= 1'b0;
    end
`endif

    // One-cycle registered response for whichever port was granted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_rv_q  <= 1'b0;
            a_err_q <= 1'b0;
            a_rd_q  <= '0;
            b_rv_q  <= 1'b0;
            b_err_q <= 1'b0;
            b_rd_q  <= '0;
        end else begin
            a_rv_q  <= gnt_a;
            a_err_q <= gnt_a & g_err;
            a_rd_q  <= (gnt_a && !g_we && !g_err) ? mem_rdata : '0;
            b_rv_q  <= gnt_b;
            b_err_q <= gnt_b & g_err;
            b_rd_q  <= (gnt_b && !g_we && !g_err) ? mem_rdata : '0;
        end
    end

    // A response pending when reset asserts is dropped, not presented
    assign a.rvalid = a_rv_q & rst_n;
    assign a.err    = a_err_q & rst_n;
    assign a.rdata  = a_rd_q;
    assign b.rvalid = b_rv_q & rst_n;
    assign b.err    = b_err_q & rst_n;
    assign b.rdata  = b_rd_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected responses into
// per-port queues; a forked monitor pops and compares on every rvalid.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        lock_timeout;

    dmem_port_if pa ();
    dmem_port_if pb ();

    dmem_arbiter #(.LOCK_TIMEOUT(16), .MEM_WORDS(1024)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a            (pa),
        .b            (pb),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .lock_timeout (lock_timeout)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, posedge write
    logic [31:0] mem [0:1023];
    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } rsp_t;

    rsp_t qa[$];
    rsp_t qb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_a(input logic rq, we, lk, input logic [31:0] ad, wd);
        pa.req = rq; pa.we = we; pa.lock = lk; pa.addr = ad; pa.wdata = wd;
    endtask

    task automatic set_b(input logic rq, we, lk, input logic [31:0] ad, wd);
        pb.req = rq; pb.we = we; pb.lock = lk; pb.addr = ad; pb.wdata = wd;
    endtask

    // Check one cycle's grants, queue the expected responses, advance a clock
    task automatic chk(input logic ega, egb, ewe,
                       input logic [31:0] ard = '0, input logic aerr = 1'b0,
                       input logic [31:0] brd = '0, input logic berr = 1'b0,
                       input logic ets = 1'b0, input logic push = 1'b1);
        #1;
        cmp("a_gnt", 32'(pa.gnt), 32'(ega));
        cmp("b_gnt", 32'(pb.gnt), 32'(egb));
        cmp("mem_we", 32'(mem_we), 32'(ewe));
        cmp("lock_timeout", 32'(lock_timeout), 32'(ets));
        if (push && ega) qa.push_back('{rd: ard, err: aerr});
        if (push && egb) qb.push_back('{rd: brd, err: berr});
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        rst_n = 1'b0;
        set_a(1, 1, 0, 32'h10, 32'h1);
        set_b(1, 0, 0, 32'h20, 32'h0);

        fork
            begin : monitor
                rsp_t r;
                forever begin
                    @(negedge clk);
                    if (pa.rvalid === 1'b1) begin
                        if (qa.size() == 0) cmp("a_unexpected_rvalid", 32'(qa.size()), 32'd1);
                        else begin
                            r = qa.pop_front();
                            cmp("a_rdata", pa.rdata, r.rd);
                            cmp("a_err", 32'(pa.err), 32'(r.err));
                        end
                    end
                    if (pb.rvalid === 1'b1) begin
                        if (qb.size() == 0) cmp("b_unexpected_rvalid", 32'(qb.size()), 32'd1);
                        else begin
                            r = qb.pop_front();
                            cmp("b_rdata", pb.rdata, r.rd);
                            cmp("b_err", 32'(pb.err), 32'(r.err));
                        end
                    end
                end
            end
        join_none

        // Reset state with both ports requesting
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_a_gnt", 32'(pa.gnt), 0);
        cmp("rst_b_gnt", 32'(pb.gnt), 0);
        cmp("rst_mem_we", 32'(mem_we), 0);
        cmp("rst_a_rvalid", 32'(pa.rvalid), 0);
        cmp("rst_b_rvalid", 32'(pb.rvalid), 0);
        cmp("rst_lock_timeout", 32'(lock_timeout), 0);
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk(0, 0, 0);

        // Read after write on A
        set_a(1, 1, 0, 32'h10, 32'hDEADBEEF); chk(1, 0, 1, 32'h0, 0);
        set_a(1, 0, 0, 32'h10, 32'h0);        chk(1, 0, 0, 32'hDEADBEEF, 0);

        // Misaligned and out-of-range writes error and do not write
        set_a(1, 1, 0, 32'h13, 32'h11111111);   chk(1, 0, 0, 32'h0, 1);
        set_a(1, 1, 0, 32'h1000, 32'h22222222); chk(1, 0, 0, 32'h0, 1);
        set_a(1, 0, 0, 32'h10, 32'h0);          chk(1, 0, 0, 32'hDEADBEEF, 0);
        set_a(1, 0, 0, 32'h0, 32'h0);           chk(1, 0, 0, 32'h0, 0);

        // B writes alone
        set_a(0, 0, 0, 0, 0);
        set_b(1, 1, 0, 32'h20, 32'hCAFEF00D); chk(0, 1, 1, 0, 0, 32'h0, 0);

        // Contention on reads
        set_a(1, 0, 0, 32'h10, 32'h0);
        set_b(1, 0, 0, 32'h20, 32'h0);
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
            if (i % 2 == 0) chk(1, 0, 0, 32'hDEADBEEF, 0);
            else            chk(0, 1, 0, 0, 0, 32'hCAFEF00D, 0);
`else
            chk(1, 0, 0, 32'hDEADBEEF, 0);
`endif
        end
        set_a(0, 0, 0, 0, 0);
        chk(0, 1, 0, 0, 0, 32'hCAFEF00D, 0);
        set_b(0, 0, 0, 0, 0);
        chk(0, 0, 0);

        // Lock: B blocked until A's unlocking write
        set_a(1, 0, 1, 32'h20, 32'h0);
        set_b(1, 0, 0, 32'h10, 32'h0);
        chk(1, 0, 0, 32'hCAFEF00D, 0);
        set_a(0, 0, 0, 0, 0);                 chk(0, 0, 0);
        set_a(1, 1, 0, 32'h20, 32'h12345678); chk(1, 0, 1, 32'h0, 0);
        set_a(0, 0, 0, 0, 0);                 chk(0, 1, 0, 0, 0, 32'hDEADBEEF, 0);
        set_b(0, 0, 0, 0, 0);                 chk(0, 0, 0);

        // Lock timeout after 16 idle cycles
        set_a(1, 0, 1, 32'h20, 32'h0);
        set_b(1, 0, 0, 32'h20, 32'h0);
        chk(1, 0, 0, 32'h12345678, 0);
        set_a(0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) chk(0, 0, 0);
        chk(0, 1, 0, 0, 0, 32'h12345678, 0, 1);
        set_b(0, 0, 0, 0, 0);
        chk(0, 0, 0);

        // Erroring locked access still takes the lock
        set_a(1, 0, 1, 32'h22, 32'h0);
        set_b(1, 0, 0, 32'h10, 32'h0);
        chk(1, 0, 0, 32'h0, 1);
        set_a(0, 0, 0, 0, 0);                 chk(0, 0, 0);

        // Reset mid-lock: pending response dropped, no timeout pulse
        set_a(1, 0, 1, 32'h20, 32'h0);
        chk(1, 0, 0, 32'h0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        set_a(0, 0, 0, 0, 0);
        #1;
        cmp("rstlock_a_rvalid", 32'(pa.rvalid), 0);
        chk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        chk(0, 1, 0, 0, 0, 32'hDEADBEEF, 0);
        set_b(0, 0, 0, 0, 0);

        // Final read-back
        set_a(1, 0, 0, 32'h20, 32'h0); chk(1, 0, 0, 32'h12345678, 0);
        set_a(1, 0, 0, 32'h10, 32'h0); chk(1, 0, 0, 32'hDEADBEEF, 0);
        set_a(0, 0, 0, 0, 0);
        repeat (3) chk(0, 0, 0);

        cmp("a_queue_drained", 32'(qa.size()), 0);
        cmp("b_queue_drained", 32'(qb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 16, meaning max idle cycles a locked owner may hold grant without req.
REQ-002 SHALL have parameter MEM_WORDS, default 1024, meaning data memory depth in 32-bit words.
REQ-003 SHALL have ports: clk  in  1  rising-edge clock.
REQ-004 SHALL have ports: rst_n  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have ports: a_req/b_req  in  1  access request, port A (core LSU), port B (loader/debug).
REQ-006 SHALL have ports: a_we/b_we  in  1  1 = write, 0 = read.
REQ-007 SHALL have ports: a_lock/b_lock  in  1  keep grant after this access (atomic RMW).
REQ-008 SHALL have ports: a_addr/b_addr  in  32  byte address; a_wdata/b_wdata  in  32  write data.
REQ-009 SHALL have ports: a_gnt/b_gnt  out  1  request accepted this cycle (combinational).
REQ-010 SHALL have ports: a_rvalid/b_rvalid  out  1  response valid; a_rdata/b_rdata  out  32; a_err/b_err  out  1.
REQ-011 SHALL have ports: mem_we  out  1; mem_addr  out  32; mem_wdata  out  32; mem_rdata  in  32 (memory has combinational read, posedge write).
REQ-012 SHALL have ports: lock_timeout  out  1  one-cycle pulse when a lock is force-released.

Function
REQ-013 SHALL grant at most one port per cycle; gnt = req AND selected; a requester holds req/addr/wdata/we/lock stable until gnt.
REQ-014 SHALL drive mem_addr/mem_wdata from the granted port; mem_we = granted we AND NOT error; mem_we = 0 and mem_addr = 0 when no grant.
REQ-015 SHALL flag error when addr[1:0] != 0 or addr[31:2] >= MEM_WORDS; erroring accesses perform no write.
REQ-016 SHALL register the response: cycle after gnt, the granted port's rvalid = 1 for exactly one cycle, rdata = mem_rdata sampled at grant (0 for writes or errors), err = error flag.
REQ-017 SHALL support back-to-back grants every cycle (throughput 1 access/cycle, read latency 1).
REQ-018 SHALL implement FSM states ARB, LOCK_A, LOCK_B.
REQ-019 In ARB: single requester wins; on simultaneous requests the winner follows REQ-027/028; granted access with lock=1 -> LOCK_<port>, else stay ARB.
REQ-020 In LOCK_X: only X may be granted; other port's gnt = 0; granted X access with lock=0 -> ARB; granted erroring access still obeys its lock bit.
REQ-021 In LOCK_X: idle counter increments each cycle X_req = 0, clears on X grant; reaching LOCK_TIMEOUT -> ARB, lock_timeout pulses one cycle, counter clears.
REQ-022 Response register updates regardless of FSM state; a response is never dropped or duplicated.

Reset
REQ-023 On rst_n = 0 at posedge: FSM = ARB, idle counter = 0, round-robin pointer = A, all rvalid/err = 0, all rdata = 0, lock_timeout = 0.
REQ-024 While rst_n = 0: a_gnt = b_gnt = 0, mem_we = 0; an access granted the cycle before reset asserts produces no rvalid.
REQ-025 Reset mid-lock SHALL release the lock without a lock_timeout pulse.

Configuration
REQ-026 Macro DMEM_ARB_RR_EN SHALL select the tie-break policy in ARB.
REQ-027 With DMEM_ARB_RR_EN defined: round-robin; pointer flips to the other port after each ARB-state grant; tie goes to pointer's port.
REQ-028 Without DMEM_ARB_RR_EN: fixed priority, A always wins ties; no pointer register.

Verification
REQ-029 Read after write: A writes 0xDEADBEEF @0x10, next cycle A reads 0x10 -> a_rvalid next cycle, a_rdata = 0xDEADBEEF, a_err = 0.
REQ-030 Contention: A and B both req reads 4 cycles -> RR: grants A,B,A,B; fixed: A,A,A,A with B_gnt = 0.
REQ-031 Errors: A writes 0x13 and 0x1000 -> a_err = 1 both, mem_we = 0, subsequent read @0x10 unchanged.
REQ-032 Lock: A read @0x20 lock=1, B req held -> B_gnt = 0 until A write @0x20 lock=0 granted; B granted next cycle.
REQ-033 Timeout: A locks then drops req, B req held -> lock_timeout pulse after 16 idle cycles, b_gnt = 1 same cycle after.
REQ-034 Reset mid-lock: rst_n low 1 cycle in LOCK_A -> FSM ARB, no rvalid, lock_timeout = 0, B granted after release.
